// File: rtl/umi_switch_ingress_if.sv
// rtl/umi_switch_ingress_if.sv - UMI stream bundle with master/slave modports
interface umi_switch_ingress_if #(
   parameter int VW = 1,
   parameter int DW = 256,
   parameter int AW = 64,
   parameter int CW = 32
);
   logic [VW-1:0] valid;
   logic [CW-1:0] cmd;
   logic [AW-1:0] dstaddr;
   logic [AW-1:0] srcaddr;
   logic [DW-1:0] data;
   logic          ready;

   modport master (output valid, cmd, dstaddr, srcaddr, data, input ready);
   modport slave  (input valid, cmd, dstaddr, srcaddr, data, output ready);
endinterface

// File: rtl/umi_switch_ingress.sv
// rtl/umi_switch_ingress.sv - per-input switch ingress: 2-entry FIFO, port decode, drop counter
module umi_switch_ingress #(
   parameter int M       = 4,
   parameter int DW      = 256,
   parameter int AW      = 64,
   parameter int CW      = 32,
   parameter int PORTLSB = 40,
   parameter int PORTW   = 16,
   parameter int ERRW    = 16
) (
   input  logic                 clk,
   input  logic                 nreset,
   umi_switch_ingress_if.slave  umi_in,
   umi_switch_ingress_if.master umi_out,
   input  logic                 err_clear,
   output logic                 err_pulse,
   output logic [ERRW-1:0]      err_count
);

   logic [CW-1:0]    mem_cmd [2];
   logic [AW-1:0]    mem_dst [2];
   logic [AW-1:0]    mem_src [2];
   logic [DW-1:0]    mem_data[2];
   logic [M-1:0]     mem_req [2];
   logic             rd_ptr;
   logic             wr_ptr;
   logic [1:0]       count;

   logic [PORTW-1:0] port;
   logic [M-1:0]     req;
   logic             in_range;
   logic             accept;
   logic             push;
   logic             drop;
   logic             pop;

   // One-hot decode; an all-zero result means the port field is out of range.
   always_comb begin
      port = umi_in.dstaddr[PORTLSB +: PORTW];
      req  = '0;
      for (int j = 0; j < M; j++) begin
         if (port == PORTW'(j)) req[j] = 1'b1;
      end
      in_range = |req;
   end

   assign umi_in.ready = (count != 2'd2);
   assign accept       = umi_in.valid[0] & umi_in.ready;
   assign push         = accept & in_range;
   assign drop         = accept & ~in_range;

   assign umi_out.valid   = (count != 2'd0) ? mem_req[rd_ptr] : '0;
   assign umi_out.cmd     = mem_cmd[rd_ptr];
   assign umi_out.dstaddr = mem_dst[rd_ptr];
   assign umi_out.srcaddr = mem_src[rd_ptr];
   assign umi_out.data    = mem_data[rd_ptr];
   assign pop             = (|umi_out.valid) & umi_out.ready;

   // Storage is cleared on reset so the payload outputs read zero.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         for (int i = 0; i < 2; i++) begin
            mem_cmd[i]  <= '0;
            mem_dst[i]  <= '0;
            mem_src[i]  <= '0;
            mem_data[i] <= '0;
            mem_req[i]  <= '0;
         end
         rd_ptr <= 1'b0;
         wr_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (push) begin
            mem_cmd[wr_ptr]  <= umi_in.cmd;
            mem_dst[wr_ptr]  <= umi_in.dstaddr;
            mem_src[wr_ptr]  <= umi_in.srcaddr;
            mem_data[wr_ptr] <= umi_in.data;
            mem_req[wr_ptr]  <= req;
            wr_ptr           <= wr_ptr + 1'b1;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         count <= count + 2'(push) - 2'(pop);
      end
   end

   // A clear coinciding with a drop leaves that drop counted.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         err_pulse <= 1'b0;
         err_count <= '0;
      end else begin
         err_pulse <= drop;
         if (err_clear)
            err_count <= drop ? ERRW'(1) : '0;
         else if (drop && !(&err_count))
            err_count <= err_count + ERRW'(1);
      end
   end

endmodule

// File: doc/umi_switch_ingress.md
Name: umi_switch_ingress

Overview:
Per-input ingress stage that sits directly upstream of one umi_switch input port.
- Accepts a single UMI stream and buffers it in a 2-entry FIFO.
- Decodes the destination port field of dstaddr into a one-hot per-output request vector, which drives that input's slice of the switch's umi_in_valid.
- Discards transactions whose port field is out of range and counts them.
- Registered boundary: no combinational path from switch ready back to the source.

Parameters:
M, 4, number of switch outputs; width of the request vector
DW, 256, UMI data width
AW, 64, UMI address width
CW, 32, UMI command width
PORTLSB, 40, LSB of the destination port field in dstaddr
PORTW, 16, width of the destination port field
ERRW, 16, width of the error counter

Ports:
clk  input  1  clock
nreset  input  1  asynchronous active-low reset
umi_in_valid  input  1  source transaction valid
umi_in_cmd  input  CW  source command
umi_in_dstaddr  input  AW  source destination address
umi_in_srcaddr  input  AW  source source address
umi_in_data  input  DW  source data
umi_in_ready  output  1  ingress can accept
umi_out_valid  output  M  one-hot request to switch, bit j = destined for output j
umi_out_cmd  output  CW  head command
umi_out_dstaddr  output  AW  head destination address
umi_out_srcaddr  output  AW  head source address
umi_out_data  output  DW  head data
umi_out_ready  input  1  switch accepted head (this input's umi_in_ready)
err_clear  input  1  synchronous clear of error counter
err_pulse  output  1  one-cycle pulse per dropped transaction
err_count  output  ERRW  saturating count of dropped transactions

Behaviour:
- Reset (nreset low, asynchronous):
  - FIFO count = 0, umi_out_valid = 0, err_pulse = 0, err_count = 0, payload outputs = 0.
  - umi_in_ready = 1 in the first cycle after nreset deasserts.
- umi_in_ready = (count < 2):
  - Registered-state only; independent of umi_out_ready in the same cycle.
- Accept occurs when umi_in_valid & umi_in_ready.
  - Decode port = umi_in_dstaddr[PORTLSB +: PORTW].
  - port < M: push the entry {cmd, dstaddr, srcaddr, data, onehot(port)}.
  - port >= M: no push; err_pulse = 1 on the next cycle; err_count increments and saturates at all-ones.
  - A dropped transaction is still handshaken: the source sees it as consumed.
- Output:
  - umi_out_valid = head onehot when count > 0, else 0.
  - At most one bit is ever set.
  - Payload outputs reflect the head entry.
- Pop occurs when (|umi_out_valid) & umi_out_ready.
- Stability: while umi_out_valid != 0 and no pop, umi_out_valid and all payload outputs hold constant.
- Latency: a transaction accepted in cycle t appears on umi_out_* in cycle t+1 if the FIFO was empty.
- Throughput: 1 transaction/cycle sustained when umi_out_ready is held high.
- Push and pop in the same cycle:
  - count unchanged; FIFO order preserved.
  - Allowed only when count is 1, since push requires count < 2.
- Full (count = 2): umi_in_ready = 0; a pop that cycle raises ready the next cycle.
- Empty: umi_out_ready is ignored.
- err_clear:
  - err_clear alone: err_count becomes 0 next cycle.
  - err_clear with a simultaneous drop event: err_count becomes 1.
  - err_pulse is unaffected by err_clear.
- Reset asserted mid-operation: FIFO contents are discarded immediately and outputs return to reset values asynchronously.
- FIFO storage: 2-entry circular buffer with a 1-bit read pointer, a 1-bit write pointer and a 2-bit count.
  - Pointers wrap 1 -> 0.

Test Plan:
- Reset/idle: hold nreset low 5 cycles, then release -> umi_out_valid = 0, err_count = 0, umi_in_ready = 1 on the first cycle after release.
- Routing: send dstaddr port fields 0, 1, 2, 3 with data 0xA0..0xA3 and umi_out_ready = 1 -> umi_out_valid = 0001, 0010, 0100, 1000 on consecutive cycles, each 1 cycle after accept, data in order.
- Backpressure: umi_out_ready = 0, offer 3 transactions:
  - umi_in_ready drops after the 2nd accept; the 3rd is held.
  - Head payload is stable for all stalled cycles.
  - Set umi_out_ready = 1 -> all 3 delivered in order, no loss or duplication.
- Out of range: port field 4 and 0xFFFF interleaved with valid port 2:
  - The two bad transactions are accepted but not forwarded.
  - err_pulse fires 2 times; err_count = 2.
  - The port-2 transaction is delivered with umi_out_valid = 0100.
- Counter edge, ERRW = 4: 17 bad transactions -> err_count saturates at 15. Then err_clear together with a bad transaction -> err_count = 1.
- Random stress: random valid and umi_out_ready (50%) over 10k transactions -> scoreboard order/data match, never more than one umi_out_valid bit set. Assert reset mid-burst -> FIFO empties, and traffic resumes cleanly after release.
